// File: rtl/pix_pkt_pkg.sv
// Shared types and default geometry for the framed pixel stream source.
package pix_pkt_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int unsigned DEF_COL = 640;
    localparam int unsigned DEF_ROW = 480;
    localparam int unsigned DEF_DW  = 8;
    localparam int unsigned COL_W   = $clog2(DEF_COL);
    localparam int unsigned ROW_W   = $clog2(DEF_ROW);

endpackage

// File: rtl/pix_pkt_cnt.sv
// Column/row position counter for pix_pkt_gen; clear and increment may
// coincide, in which case the incremented pixel is (0,0).
module pix_pkt_cnt
    import pix_pkt_pkg::*;
#(
    parameter  int unsigned COL = DEF_COL,
    parameter  int unsigned ROW = DEF_ROW,
    localparam int unsigned CW  = $clog2(COL),
    localparam int unsigned RW  = $clog2(ROW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt_col,
    output logic [RW-1:0] cnt_row,
    output logic          last_pix_c
);

    logic          last_col;
    logic          last_row;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;

    assign last_col   = (cnt_col == CW'(COL - 1));
    assign last_row   = (cnt_row == RW'(ROW - 1));
    assign last_pix_c = last_col && last_row;

    // COL >= 2, so a cleared counter stepping once always lands on column 1
    always_comb begin
        col_nxt = cnt_col;
        row_nxt = cnt_row;
        if (clr) begin
            col_nxt = inc ? CW'(1) : '0;
            row_nxt = '0;
        end else if (inc) begin
            if (last_col) begin
                col_nxt = '0;
                row_nxt = last_row ? '0 : cnt_row + RW'(1);
            end else begin
                col_nxt = cnt_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_col <= '0;
            cnt_row <= '0;
        end else begin
            cnt_col <= col_nxt;
            cnt_row <= row_nxt;
        end
    end

endmodule

// File: rtl/pix_pkt_gen.sv
// Framed pixel stream source: counts columns/rows, marks sop/eop, resyncs on frame_start.
// Optional test pattern (col ^ row) enabled by defining PIX_PKT_TEST_PATTERN_EN.
module pix_pkt_gen
    import pix_pkt_pkg::*;
#(
    parameter int unsigned COL = DEF_COL,
    parameter int unsigned ROW = DEF_ROW,
    parameter int unsigned DW  = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_in_vld,
    input  logic          frame_start,
`ifdef PIX_PKT_TEST_PATTERN_EN
    input  logic          tp_sel,
`endif
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          busy,
    output logic          err
);

    localparam int unsigned CW = $clog2(COL);
    localparam int unsigned RW = $clog2(ROW);

    state_t        state_q;
    state_t        state_nxt;
    logic [CW-1:0] cnt_col;
    logic [RW-1:0] cnt_row;
    logic          last_pix_c;
    logic          mid_frame_c;
    logic          accept_c;
    logic [DW-1:0] pix_sel_c;
    logic [DW-1:0] dout_nxt;
    logic          vld_nxt;
    logic          sop_nxt;
    logic          eop_nxt;
    logic          err_nxt;

    pix_pkt_cnt #(
        .COL (COL),
        .ROW (ROW)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (frame_start),
        .inc        (accept_c),
        .cnt_col    (cnt_col),
        .cnt_row    (cnt_row),
        .last_pix_c (last_pix_c)
    );

    assign mid_frame_c = (cnt_col != '0) || (cnt_row != '0);

    // A pixel coinciding with frame_start sits at (0,0) regardless of the counters
`ifdef PIX_PKT_TEST_PATTERN_EN
    assign pix_sel_c = !tp_sel     ? pix_in :
                       frame_start ? '0     : (DW'(cnt_col) ^ DW'(cnt_row));
`else
    assign pix_sel_c = pix_in;
`endif

    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        err_nxt   = 1'b0;
        dout_nxt  = dout;
        vld_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = ACTIVE;
                    accept_c  = pix_in_vld;
                    sop_nxt   = pix_in_vld;
                end else if (pix_in_vld) begin
                    err_nxt = 1'b1;
                end
            end
            ACTIVE: begin
                accept_c = pix_in_vld;
                if (frame_start) begin
                    // restart aborts the running frame; no eop is ever issued for it
                    err_nxt = mid_frame_c;
                    sop_nxt = pix_in_vld;
                end else if (pix_in_vld) begin
                    sop_nxt = !mid_frame_c;
                    eop_nxt = last_pix_c;
                    if (last_pix_c) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        vld_nxt = accept_c;
        if (accept_c) begin
            dout_nxt = pix_sel_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            dout     <= dout_nxt;
            dout_vld <= vld_nxt;
            dout_sop <= sop_nxt;
            dout_eop <= eop_nxt;
            busy     <= (state_nxt == ACTIVE);
            err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pix_pkt_gen.sv
// Self-checking bench for pix_pkt_gen (COL=4, ROW=2) against a linear-index frame model.
// Define PIX_PKT_TEST_PATTERN_EN to also exercise the test pattern.
module tb_pix_pkt_gen;

    localparam int unsigned COL  = 4;
    localparam int unsigned ROW  = 2;
    localparam int unsigned DW   = 8;
    localparam int          NPIX = COL * ROW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] pix_in;
    logic          pix_in_vld;
    logic          frame_start;
`ifdef PIX_PKT_TEST_PATTERN_EN
    logic          tp_sel;
`endif
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_sop;
    logic          dout_eop;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;

    // reference model state: frame membership and linear pixel index
    bit            m_in   = 1'b0;
    int            m_idx  = 0;
    logic [DW-1:0] m_dout = '0;
    logic          m_vld  = 1'b0;
    logic          m_sop  = 1'b0;
    logic          m_eop  = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_err  = 1'b0;

    pix_pkt_gen #(
        .COL (COL),
        .ROW (ROW),
        .DW  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_in      (pix_in),
        .pix_in_vld  (pix_in_vld),
        .frame_start (frame_start),
`ifdef PIX_PKT_TEST_PATTERN_EN
        .tp_sel      (tp_sel),
`endif
        .dout        (dout),
        .dout_vld    (dout_vld),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string got_s();
        return $sformatf("dout=%h vld=%b sop=%b eop=%b busy=%b err=%b",
                         dout, dout_vld, dout_sop, dout_eop, busy, err);
    endfunction

    function automatic string exp_s();
        return $sformatf("dout=%h vld=%b sop=%b eop=%b busy=%b err=%b",
                         m_dout, m_vld, m_sop, m_eop, m_busy, m_err);
    endfunction

    task automatic model_reset();
        m_in = 1'b0; m_idx = 0; m_dout = '0;
        m_vld = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic fs, input logic [DW-1:0] p,
                              input logic tp);
        m_vld = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0;
        if (fs) begin
            if (m_in && m_idx != 0) m_err = 1'b1;
            m_in  = 1'b1;
            m_idx = 0;
        end
        if (v) begin
            if (!m_in) begin
                m_err = 1'b1;
            end else begin
                m_vld  = 1'b1;
                m_dout = tp ? (DW'(m_idx % COL) ^ DW'(m_idx / COL)) : p;
                m_sop  = (m_idx == 0);
                m_eop  = (m_idx == NPIX - 1);
                m_idx++;
                if (m_idx == NPIX) begin
                    m_idx = 0;
                    m_in  = 1'b0;
                end
            end
        end
        m_busy = m_in;
    endtask

    // apply one cycle of input at the falling edge, sample 1 time unit after the rising edge
    task automatic drive(input logic v, input logic fs, input logic [DW-1:0] p, input logic tp);
        @(negedge clk);
        pix_in      = p;
        pix_in_vld  = v;
        frame_start = fs;
`ifdef PIX_PKT_TEST_PATTERN_EN
        tp_sel      = tp;
`endif
        model_step(v, fs, p, tp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_in = '0; pix_in_vld = 1'b0; frame_start = 1'b0;
`ifdef PIX_PKT_TEST_PATTERN_EN
        tp_sel = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dout, dout_vld, dout_sop, dout_eop, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset: got %s, required all zero", got_s());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NPIX; i++) begin
            drive(1'b1, i == 0, DW'(i + 1), 1'b0);
            checks++;
            if (dout !== DW'(i + 1) || dout_vld !== 1'b1 || dout_sop !== (i == 0)
                || dout_eop !== (i == NPIX - 1) || err !== 1'b0) begin
                errors++;
                $display("FAIL b2b pixel %0d: got %s, required dout=%h vld=1 sop=%b eop=%b err=0",
                         i, got_s(), DW'(i + 1), i == 0, i == NPIX - 1);
            end
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (busy !== 1'b0 || dout_vld !== 1'b0 || dout !== DW'(NPIX)) begin
            errors++;
            $display("FAIL b2b after: got %s, required busy=0 vld=0 dout=%h", got_s(), DW'(NPIX));
        end
    endtask

    task automatic test_gaps();
        drive(1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (busy !== 1'b1 || dout_vld !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL gaps start: got %s, required busy=1 vld=0 err=0", got_s());
        end
        for (int i = 0; i < NPIX; i++) begin
            drive(1'b1, 1'b0, DW'(i + 1), 1'b0);
            checks++;
            if (dout !== DW'(i + 1) || dout_vld !== 1'b1 || dout_sop !== (i == 0)
                || dout_eop !== (i == NPIX - 1)) begin
                errors++;
                $display("FAIL gaps pixel %0d: got %s, required dout=%h vld=1 sop=%b eop=%b",
                         i, got_s(), DW'(i + 1), i == 0, i == NPIX - 1);
            end
            drive(1'b0, 1'b0, 8'hEE, 1'b0);
            checks++;
            if (dout_vld !== 1'b0 || dout !== DW'(i + 1) || dout_sop !== 1'b0
                || dout_eop !== 1'b0 || busy !== (i != NPIX - 1)) begin
                errors++;
                $display("FAIL gaps hold %0d: got %s, required vld=0 dout=%h busy=%b",
                         i, got_s(), DW'(i + 1), i != NPIX - 1);
            end
        end
    endtask

    task automatic test_idle_err();
        drive(1'b1, 1'b0, 8'hAA, 1'b0);
        checks++;
        if (err !== 1'b1 || dout_vld !== 1'b0 || busy !== 1'b0 || dout !== m_dout) begin
            errors++;
            $display("FAIL idle_err pulse: got %s, required %s", got_s(), exp_s());
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (err !== 1'b0 || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_err clear: got %s, required err=0 vld=0", got_s());
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 0, DW'($urandom), 1'b0);
            checks++;
            if ({dout, dout_vld, dout_sop, dout_eop, busy, err}
                !== {m_dout, m_vld, m_sop, m_eop, m_busy, m_err}) begin
                errors++;
                $display("FAIL abort pre %0d: got %s, required %s", i, got_s(), exp_s());
            end
        end
        drive(1'b1, 1'b1, 8'h5A, 1'b0);
        checks++;
        if (err !== 1'b1 || dout_sop !== 1'b1 || dout_vld !== 1'b1 || dout !== 8'h5A
            || dout_eop !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort restart: got %s, required dout=5a vld=1 sop=1 eop=0 busy=1 err=1",
                     got_s());
        end
        for (int i = 1; i < NPIX; i++) begin
            drive(1'b1, 1'b0, DW'($urandom), 1'b0);
            checks++;
            if ({dout, dout_vld, dout_sop, dout_eop, busy, err}
                !== {m_dout, m_vld, m_sop, m_eop, m_busy, m_err}
                || dout_eop !== (i == NPIX - 1)) begin
                errors++;
                $display("FAIL abort post %0d: got %s, required %s", i, got_s(), exp_s());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 0, DW'(8'h10 + i), 1'b0);
        end
        @(negedge clk);
        pix_in_vld = 1'b0; frame_start = 1'b0; rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({dout, dout_vld, dout_sop, dout_eop, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid async: got %s, required all zero", got_s());
        end
        @(posedge clk);
        #1;
        checks++;
        if ({dout, dout_vld, dout_sop, dout_eop, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid held: got %s, required all zero", got_s());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            drive(1'b1, i == 0, DW'(8'h40 + i), 1'b0);
            checks++;
            if (dout !== DW'(8'h40 + i) || dout_sop !== (i == 0)
                || dout_eop !== (i == NPIX - 1) || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid frame %0d: got %s, required dout=%h sop=%b eop=%b err=0",
                         i, got_s(), DW'(8'h40 + i), i == 0, i == NPIX - 1);
            end
        end
    endtask

`ifdef PIX_PKT_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [DW-1:0] pat [NPIX] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd0, 8'd3, 8'd2};
        for (int i = 0; i < NPIX; i++) begin
            drive(1'b1, i == 0, DW'($urandom), 1'b1);
            checks++;
            if (dout !== pat[i] || dout_vld !== 1'b1 || dout_sop !== (i == 0)
                || dout_eop !== (i == NPIX - 1)) begin
                errors++;
                $display("FAIL pattern %0d: got %s, required dout=%h sop=%b eop=%b",
                         i, got_s(), pat[i], i == 0, i == NPIX - 1);
            end
        end
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic v;
        logic fs;
        logic tp;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 99) < 70);
            fs = ($urandom_range(0, 99) < 4);
`ifdef PIX_PKT_TEST_PATTERN_EN
            tp = 1'($urandom);
`else
            tp = 1'b0;
`endif
            drive(v, fs, DW'($urandom), tp);
            checks++;
            if ({dout, dout_vld, dout_sop, dout_eop, busy, err}
                !== {m_dout, m_vld, m_sop, m_eop, m_busy, m_err}) begin
                errors++;
                $display("FAIL random cyc %0d: got %s, required %s", i, got_s(), exp_s());
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_idle_err();
        test_abort();
        test_reset_mid();
`ifdef PIX_PKT_TEST_PATTERN_EN
        test_pattern();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
